cmp_tracker: RTL and testbench
==============================

Name: cmp_tracker

Overview:
- Downstream stage of the 4-bit magnitude comparator. Consumes its one-hot relation flags: y1 (a==b), y2 (a>b), y3 (a<b).
- Debounces the relation. A new relation is accepted only after HOLD consecutive valid samples agree.
- Reports the stable relation, one-cycle crossing pulses and a saturating run-length count.
- Flags illegal (non-one-hot) flag combinations.

Parameters:
HOLD, 3, consecutive identical valid samples needed to commit a relation; legal range 1..15
CNT_W, 8, width of run_len counter

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  y1/y2/y3 are sampled this cycle; when 0 the flags are don't-care
y1  input  1  comparator equal flag
y2  input  1  comparator greater flag
y3  input  1  comparator less flag
rel  output  2  stable relation: 00 NONE, 01 EQ, 10 GT, 11 LT
rel_valid  output  1  high once any relation has been committed
rise  output  1  one-cycle pulse: stable relation moved to a higher rank (ordering LT<EQ<GT)
fall  output  1  one-cycle pulse: stable relation moved to a lower rank
run_len  output  CNT_W  valid samples matching rel since its last commit, saturating
err  output  1  one-cycle pulse: illegal flag combination sampled

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high, and it dominates all other inputs.
- Reset values: rel=00, rel_valid=0, rise=0, fall=0, run_len=0, err=0. Candidate register=NONE, cand_cnt=0.
- FSM has two states:
  - IDLE: nothing committed yet; rel_valid=0.
  - STABLE: rel holds EQ/GT/LT; rel_valid=1.
  - IDLE->STABLE on the first commit. There is no return to IDLE except via rst.
- Each cycle with in_valid=1, the flags are decoded:
  - Legal: exactly one of y1/y2/y3 high, giving code c.
  - Illegal: zero or more than one high.
- Legal sample, candidate tracking:
  - If c==cand, cand_cnt increments, saturating at HOLD.
  - Otherwise cand<=c and cand_cnt<=1.
- Commit happens when the updated cand_cnt==HOLD and (state==IDLE or c!=rel). On commit:
  - rel<=c and run_len<=HOLD (saturated to 2^CNT_W-1).
  - In STABLE, rise or fall is asserted according to rank. No pulse on the IDLE->STABLE commit.
- Legal sample with c==rel in STABLE: run_len increments, saturating at 2^CNT_W-1.
- Legal sample with c!=rel and no commit: run_len holds.
- Illegal sample:
  - err=1 on the next cycle.
  - cand_cnt<=0 (the candidate run is broken).
  - rel and run_len are unchanged.
- in_valid=0: no state changes. rise, fall and err deassert.
- Latency: all outputs are registered and reflect the sample taken at the preceding edge. With HOLD=1, every legal differing sample commits immediately.
- rise, fall and err are never high for more than one cycle per triggering sample. rise and fall are never high together.
- Reset mid-operation: a partial candidate run is discarded, and counting restarts from zero after rst deasserts.

Decomposition:
- Package cmp_pkg holds:
  - relation constants REL_NONE/REL_EQ/REL_GT/REL_LT (2-bit);
  - FSM state encoding ST_IDLE/ST_STABLE;
  - a rank function mapping relation code to 0..2.
- One natural sub-module, cmp_decode: combinational. Maps y1/y2/y3 to a 2-bit code plus an illegal flag.
- cmp_tracker instantiates cmp_decode and holds all registers and the FSM.

Test Plan (HOLD=3, CNT_W=4):
1. rst, then valid LT,LT,LT (y3=1) -> after 3rd edge rel=11, rel_valid=1, rise=0, fall=0, run_len=3; before that rel_valid=0.
2. From stable LT, valid GT x3 -> rel=10 and rise=1 for exactly one cycle after the 3rd GT, run_len=3. 12 more GT samples -> run_len saturates at 15, with no further pulses.
3. Stable GT with run_len=3, then EQ,EQ,GT,EQ,EQ -> rel stays 10, no rise/fall, run_len=4 after the GT sample.
4. Stable GT, then LT,LT,(y1=y2=1),LT,LT,LT -> err=1 one cycle after the illegal sample. Commit to LT only on the 6th sample, with fall=1 once.
5. Stable GT, then LT, in_valid=0 for 5 cycles with y1=y2=y3=1, then LT,LT -> commit on the 3rd valid LT, err never asserted during the gap.
6. From IDLE, LT,LT, then rst for 1 cycle, then LT once -> all outputs at reset values after rst. No commit after the single LT; rel_valid=0.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared definitions for the comparator relation tracker.
//   rel_t      : 2-bit relation code (NONE/EQ/GT/LT)
//   state_t    : tracker FSM state encoding
//   CAND_W     : width of the candidate agreement counter (covers HOLD up to 15)
//   rel_rank() : orders relations LT < EQ < GT for rise/fall detection
package cmp_pkg;

  typedef logic [1:0] rel_t;

  localparam rel_t REL_NONE = 2'b00;
  localparam rel_t REL_EQ   = 2'b01;
  localparam rel_t REL_GT   = 2'b10;
  localparam rel_t REL_LT   = 2'b11;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STABLE = 1'b1
  } state_t;

  localparam int CAND_W = 4;

  // NONE never takes part in a rank comparison; it maps to 0 only so the
  // function is total.
  function automatic logic [1:0] rel_rank(input rel_t r);
    case (r)
      REL_LT:  return 2'd0;
      REL_EQ:  return 2'd1;
      REL_GT:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/cmp_tracker_if.sv
// Bundle between the comparator and the relation tracker.
//   in_valid, y1 (eq), y2 (gt), y3 (lt) : comparator sample, driven by master
//   rel, rel_valid, rise, fall,
//   run_len, err                        : tracker status, driven by slave
// Modports: master = sample source / status consumer, slave = tracker.
interface cmp_tracker_if
  import cmp_pkg::*;
#(
  parameter int CNT_W = 8
);

  logic             in_valid;
  logic             y1;
  logic             y2;
  logic             y3;
  rel_t             rel;
  logic             rel_valid;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] run_len;
  logic             err;

  modport master (
    output in_valid, y1, y2, y3,
    input  rel, rel_valid, rise, fall, run_len, err
  );

  modport slave (
    input  in_valid, y1, y2, y3,
    output rel, rel_valid, rise, fall, run_len, err
  );

endinterface

// File: rtl/cmp_decode.sv
// Combinational decode of the comparator's one-hot relation flags.
//   y1, y2, y3 : equal / greater / less flags
//   code       : REL_EQ / REL_GT / REL_LT for a legal one-hot input, else REL_NONE
//   illegal    : high when zero or more than one flag is set
module cmp_decode
  import cmp_pkg::*;
(
  input  logic y1,
  input  logic y2,
  input  logic y3,
  output rel_t code,
  output logic illegal
);

  always_comb begin
    code    = REL_NONE;
    illegal = 1'b0;
    case ({y1, y2, y3})
      3'b100:  code = REL_EQ;
      3'b010:  code = REL_GT;
      3'b001:  code = REL_LT;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cmp_tracker.sv
// Debounces the comparator relation and reports the stable result.
//   clk, rst  : single clock, synchronous active-high reset
//   bus.slave : in_valid/y1/y2/y3 in; rel, rel_valid, rise, fall,
//               run_len, err out (all registered)
// A relation commits after HOLD consecutive agreeing valid samples. rise/fall
// pulse on rank changes of the committed relation (LT < EQ < GT), run_len
// counts matching samples since the last commit, err flags illegal flag sets.
module cmp_tracker
  import cmp_pkg::*;
#(
  parameter int HOLD  = 3,
  parameter int CNT_W = 8
)(
  input  logic         clk,
  input  logic         rst,
  cmp_tracker_if.slave bus
);

  localparam logic [CAND_W-1:0] HOLD_C = CAND_W'(HOLD);
  // run_len is loaded with HOLD on commit, clipped to what CNT_W can hold.
  localparam logic [CNT_W-1:0] HOLD_RUN =
    (longint'(HOLD) >= (longint'(1) << CNT_W)) ? {CNT_W{1'b1}} : CNT_W'(HOLD);

  function automatic logic [CNT_W-1:0] sat_inc_run(input logic [CNT_W-1:0] x);
    return (x == {CNT_W{1'b1}}) ? x : x + CNT_W'(1);
  endfunction

  function automatic logic [CAND_W-1:0] sat_inc_cand(input logic [CAND_W-1:0] x);
    return (x >= HOLD_C) ? HOLD_C : x + CAND_W'(1);
  endfunction

  rel_t code_p0;
  logic illegal_p0;

  cmp_decode u_decode (
    .y1      (bus.y1),
    .y2      (bus.y2),
    .y3      (bus.y3),
    .code    (code_p0),
    .illegal (illegal_p0)
  );

  state_t            state_p1,   state_nxt;
  rel_t              cand_p1,    cand_nxt;
  logic [CAND_W-1:0] cand_cnt_p1, cand_cnt_nxt;
  rel_t              rel_p1,     rel_nxt;
  logic [CNT_W-1:0]  run_len_p1, run_len_nxt;
  logic              rise_p1,    rise_nxt;
  logic              fall_p1,    fall_nxt;
  logic              err_p1,     err_nxt;

  // ---- p0: decoded sample -> next state ----
  always_comb begin
    logic [CAND_W-1:0] cnt_upd;
    logic              commit;

    state_nxt    = state_p1;
    cand_nxt     = cand_p1;
    cand_cnt_nxt = cand_cnt_p1;
    rel_nxt      = rel_p1;
    run_len_nxt  = run_len_p1;
    rise_nxt     = 1'b0;
    fall_nxt     = 1'b0;
    err_nxt      = 1'b0;
    cnt_upd      = '0;
    commit       = 1'b0;

    if (bus.in_valid) begin
      if (illegal_p0) begin
        // An illegal sample breaks the candidate run but keeps its code, so
        // the following legal sample restarts the count at 1.
        err_nxt      = 1'b1;
        cand_cnt_nxt = '0;
      end else begin
        if (code_p0 == cand_p1) begin
          cnt_upd = sat_inc_cand(cand_cnt_p1);
        end else begin
          cand_nxt = code_p0;
          cnt_upd  = CAND_W'(1);
        end
        cand_cnt_nxt = cnt_upd;

        commit = (cnt_upd == HOLD_C) &&
                 ((state_p1 == ST_IDLE) || (code_p0 != rel_p1));

        if (commit) begin
          rel_nxt     = code_p0;
          run_len_nxt = HOLD_RUN;
          state_nxt   = ST_STABLE;
          if (state_p1 == ST_STABLE) begin
            rise_nxt = rel_rank(code_p0) > rel_rank(rel_p1);
            fall_nxt = rel_rank(code_p0) < rel_rank(rel_p1);
          end
        end else if ((state_p1 == ST_STABLE) && (code_p0 == rel_p1)) begin
          run_len_nxt = sat_inc_run(run_len_p1);
        end
      end
    end
  end

  // ---- p1: registered tracker state and outputs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1    <= ST_IDLE;
      cand_p1     <= REL_NONE;
      cand_cnt_p1 <= '0;
      rel_p1      <= REL_NONE;
      run_len_p1  <= '0;
      rise_p1     <= 1'b0;
      fall_p1     <= 1'b0;
      err_p1      <= 1'b0;
    end else begin
      state_p1    <= state_nxt;
      cand_p1     <= cand_nxt;
      cand_cnt_p1 <= cand_cnt_nxt;
      rel_p1      <= rel_nxt;
      run_len_p1  <= run_len_nxt;
      rise_p1     <= rise_nxt;
      fall_p1     <= fall_nxt;
      err_p1      <= err_nxt;
    end
  end

  assign bus.rel       = rel_p1;
  assign bus.rel_valid = (state_p1 == ST_STABLE);
  assign bus.rise      = rise_p1;
  assign bus.fall      = fall_p1;
  assign bus.run_len   = run_len_p1;
  assign bus.err       = err_p1;

endmodule

// File: tb/tb_cmp_tracker.sv
// Directed bench for cmp_tracker with HOLD=3, CNT_W=4: a vector table of
// stimulus plus expected outputs, followed by hand-written gap/reset sequences.
module tb_cmp_tracker;

  localparam int HOLD  = 3;
  localparam int CNT_W = 4;

  logic clk;
  logic rst;

  cmp_tracker_if #(.CNT_W(CNT_W)) bus ();

  cmp_tracker #(.HOLD(HOLD), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       v;
    logic       y1;
    logic       y2;
    logic       y3;
    logic [1:0] rel;
    logic       rv;
    logic       rise;
    logic       fall;
    logic [3:0] run;
    logic       err;
  } vec_t;

  vec_t tbl[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic void add(input logic r, input logic v, input logic a,
                              input logic b, input logic c, input logic [1:0] rel,
                              input logic rv, input logic ri, input logic fa,
                              input logic [3:0] run, input logic er);
    vec_t e;
    e.rst = r; e.v = v; e.y1 = a; e.y2 = b; e.y3 = c;
    e.rel = rel; e.rv = rv; e.rise = ri; e.fall = fa; e.run = run; e.err = er;
    tbl.push_back(e);
  endfunction

  // Apply one vector across one rising edge and check the registered result.
  task automatic step(input string name, input vec_t e);
    rst          = e.rst;
    bus.in_valid = e.v;
    bus.y1       = e.y1;
    bus.y2       = e.y2;
    bus.y3       = e.y3;
    @(posedge clk);
    #1;
    n_vec++;
    if ({bus.rel, bus.rel_valid, bus.rise, bus.fall, bus.run_len, bus.err} !==
        {e.rel, e.rv, e.rise, e.fall, e.run, e.err}) begin
      n_fail++;
      $display("FAIL %s: got rel=%b rv=%b rise=%b fall=%b run=%0d err=%b, want rel=%b rv=%b rise=%b fall=%b run=%0d err=%b",
               name, bus.rel, bus.rel_valid, bus.rise, bus.fall, bus.run_len, bus.err,
               e.rel, e.rv, e.rise, e.fall, e.run, e.err);
    end
  endtask

  task automatic hstep(input string name, input logic r, input logic v,
                       input logic a, input logic b, input logic c,
                       input logic [1:0] rel, input logic rv, input logic ri,
                       input logic fa, input logic [3:0] run, input logic er);
    vec_t e;
    e.rst = r; e.v = v; e.y1 = a; e.y2 = b; e.y3 = c;
    e.rel = rel; e.rv = rv; e.rise = ri; e.fall = fa; e.run = run; e.err = er;
    step(name, e);
  endtask

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.y1       = 1'b0;
    bus.y2       = 1'b0;
    bus.y3       = 1'b0;

    // rst, then LT x3: commit from IDLE without a pulse
    add(1,0,0,0,0, 2'b00,0,0,0,0,0);
    add(0,1,0,0,1, 2'b00,0,0,0,0,0);
    add(0,1,0,0,1, 2'b00,0,0,0,0,0);
    add(0,1,0,0,1, 2'b11,1,0,0,3,0);
    // GT x3 from LT: rise once, then 12 more GT saturate run_len at 15
    add(0,1,0,1,0, 2'b11,1,0,0,3,0);
    add(0,1,0,1,0, 2'b11,1,0,0,3,0);
    add(0,1,0,1,0, 2'b10,1,1,0,3,0);
    for (int k = 4; k <= 15; k++) add(0,1,0,1,0, 2'b10,1,0,0,4'(k),0);
    add(0,1,0,1,0, 2'b10,1,0,0,15,0);
    // back to LT (fall), then GT again to reach stable GT with run_len=3
    add(0,1,0,0,1, 2'b10,1,0,0,15,0);
    add(0,1,0,0,1, 2'b10,1,0,0,15,0);
    add(0,1,0,0,1, 2'b11,1,0,1,3,0);
    add(0,1,0,1,0, 2'b11,1,0,0,3,0);
    add(0,1,0,1,0, 2'b11,1,0,0,3,0);
    add(0,1,0,1,0, 2'b10,1,1,0,3,0);
    // EQ,EQ,GT,EQ,EQ: interrupted candidate never commits
    add(0,1,1,0,0, 2'b10,1,0,0,3,0);
    add(0,1,1,0,0, 2'b10,1,0,0,3,0);
    add(0,1,0,1,0, 2'b10,1,0,0,4,0);
    add(0,1,1,0,0, 2'b10,1,0,0,4,0);
    add(0,1,1,0,0, 2'b10,1,0,0,4,0);
    // LT,LT,illegal,LT,LT,LT: illegal breaks the run, commit on the 6th
    add(0,1,0,0,1, 2'b10,1,0,0,4,0);
    add(0,1,0,0,1, 2'b10,1,0,0,4,0);
    add(0,1,1,1,0, 2'b10,1,0,0,4,1);
    add(0,1,0,0,1, 2'b10,1,0,0,4,0);
    add(0,1,0,0,1, 2'b10,1,0,0,4,0);
    add(0,1,0,0,1, 2'b11,1,0,1,3,0);
    // re-establish stable GT
    add(0,1,0,1,0, 2'b11,1,0,0,3,0);
    add(0,1,0,1,0, 2'b11,1,0,0,3,0);
    add(0,1,0,1,0, 2'b10,1,1,0,3,0);

    for (int i = 0; i < tbl.size(); i++) step($sformatf("vec%0d", i), tbl[i]);

    // LT, 5-cycle in_valid gap with all flags high, then LT,LT
    hstep("gap_lt1", 0,1,0,0,1, 2'b10,1,0,0,3,0);
    for (int i = 0; i < 5; i++)
      hstep($sformatf("gap_idle%0d", i), 0,0,1,1,1, 2'b10,1,0,0,3,0);
    hstep("gap_lt2", 0,1,0,0,1, 2'b10,1,0,0,3,0);
    hstep("gap_lt3", 0,1,0,0,1, 2'b11,1,0,1,3,0);
    hstep("gap_after", 0,0,0,0,0, 2'b11,1,0,0,3,0);

    // reset mid-candidate discards the partial run
    hstep("rst_a",    1,1,0,0,1, 2'b00,0,0,0,0,0);
    hstep("part_lt1", 0,1,0,0,1, 2'b00,0,0,0,0,0);
    hstep("part_lt2", 0,1,0,0,1, 2'b00,0,0,0,0,0);
    hstep("rst_b",    1,1,0,0,1, 2'b00,0,0,0,0,0);
    hstep("post_lt1", 0,1,0,0,1, 2'b00,0,0,0,0,0);
    hstep("post_lt2", 0,1,0,0,1, 2'b00,0,0,0,0,0);
    hstep("post_lt3", 0,1,0,0,1, 2'b11,1,0,0,3,0);

    // zero-hot and all-hot samples are illegal; err lasts one cycle
    hstep("zero_hot", 0,1,0,0,0, 2'b11,1,0,0,3,1);
    hstep("lt_match", 0,1,0,0,1, 2'b11,1,0,0,4,0);
    hstep("all_hot",  0,1,1,1,1, 2'b11,1,0,0,4,1);
    hstep("err_clr",  0,0,0,0,0, 2'b11,1,0,0,4,0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
